// File: rtl/feature_pkg.sv
// ============================================================================
// feature_pkg : shared widths, saturation limits and FSM state type
// Rev 1.0
// ============================================================================
`default_nettype none

package feature_pkg;

  localparam int EDGE_W  = 3;
  localparam int CURVE_W = 4;

  localparam logic [EDGE_W-1:0]  EDGE_MAX  = 3'd7;
  localparam logic [CURVE_W-1:0] CURVE_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/row_stats.sv
// ============================================================================
// row_stats : combinational per-row statistics (run count, empty, top bit)
// Rev 1.0
// ============================================================================
`default_nettype none

module row_stats
  import feature_pkg::*;
#(
  parameter int COLS   = 8,
  parameter int RUNS_W = $clog2(COLS/2+1),
  parameter int TOP_W  = $clog2(COLS)
) (
  input  logic [COLS-1:0]   row_data,
  output logic [RUNS_W-1:0] runs,
  output logic              empty,
  output logic [TOP_W-1:0]  top
);

  // A run starts wherever an ink pixel has no ink to its left (column 0 sees 0).
  logic [COLS-1:0] starts;
  assign starts = row_data & ~{row_data[COLS-2:0], 1'b0};
  assign empty  = (row_data == '0);

  always_comb begin
    runs = '0;
    top  = '0;
    for (int i = 0; i < COLS; i++) begin
      if (starts[i]) begin
        runs = runs + RUNS_W'(1);
      end
      if (row_data[i]) begin
        top = TOP_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/feature_extractor.sv
// ============================================================================
// feature_extractor : per-frame edge/curve counter feeding the perceptron
// Optional macro FEATURE_OVF_FLAG_EN adds the feat_ovf saturation flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module feature_extractor
  import feature_pkg::*;
#(
  parameter int COLS = 8,
  parameter int ROWS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COLS-1:0]    row_data,
  input  logic               row_valid,
  output logic               row_ready,
  output logic [EDGE_W-1:0]  edges,
  output logic [CURVE_W-1:0] curves,
  output logic               feat_valid,
`ifdef FEATURE_OVF_FLAG_EN
  output logic               feat_ovf,
`endif
  input  logic               feat_ready
);

  localparam int RUNS_W = $clog2(COLS/2+1);
  localparam int TOP_W  = $clog2(COLS);
  localparam int CNT_W  = $clog2(ROWS);

  logic [RUNS_W-1:0] runs;
  logic              empty;
  logic [TOP_W-1:0]  top;

  row_stats #(.COLS(COLS)) u_row_stats (
    .row_data (row_data),
    .runs     (runs),
    .empty    (empty),
    .top      (top)
  );

  state_e             state_q,      state_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [EDGE_W-1:0]  edges_q,      edges_d;
  logic [CURVE_W-1:0] curves_q,     curves_d;
  logic [RUNS_W-1:0]  prev_runs_q,  prev_runs_d;
  logic [TOP_W-1:0]   prev_top_q,   prev_top_d;
  logic               prev_empty_q, prev_empty_d;
  logic               feat_valid_q, feat_valid_d;
  logic               row_ready_q,  row_ready_d;
  logic               ovf_q,        ovf_d;

  logic               accept;
  logic               edge_ev;
  logic               curve_ev;
  logic [TOP_W-1:0]   top_diff;

  assign accept   = row_valid & row_ready_q;
  assign top_diff = (top > prev_top_q) ? (top - prev_top_q) : (prev_top_q - top);
  assign edge_ev  = (runs != prev_runs_q);
  assign curve_ev = !empty && !prev_empty_q && (top_diff == TOP_W'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    edges_d      = edges_q;
    curves_d     = curves_q;
    prev_runs_d  = prev_runs_q;
    prev_top_d   = prev_top_q;
    prev_empty_d = prev_empty_q;
    feat_valid_d = feat_valid_q;
    row_ready_d  = row_ready_q;
    ovf_d        = ovf_q;

    case (state_q)
      IDLE, ACCUM: begin
        row_ready_d = 1'b1;
        if (accept) begin
          if (edge_ev) begin
            if (edges_q != EDGE_MAX) edges_d = edges_q + EDGE_W'(1);
            else                     ovf_d   = 1'b1;
          end
          if (curve_ev) begin
            if (curves_q != CURVE_MAX) curves_d = curves_q + CURVE_W'(1);
            else                       ovf_d    = 1'b1;
          end
          prev_runs_d  = runs;
          prev_top_d   = top;
          prev_empty_d = empty;
          if (cnt_q == CNT_W'(ROWS-1)) begin
            state_d      = HOLD;
            cnt_d        = '0;
            feat_valid_d = 1'b1;
            row_ready_d  = 1'b0;
          end else begin
            state_d = ACCUM;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        row_ready_d = 1'b0;
        if (feat_ready) begin
          // Handshake: start the next frame from the same state as after reset.
          state_d      = IDLE;
          cnt_d        = '0;
          edges_d      = '0;
          curves_d     = '0;
          prev_runs_d  = '0;
          prev_top_d   = '0;
          prev_empty_d = 1'b1;
          feat_valid_d = 1'b0;
          row_ready_d  = 1'b1;
          ovf_d        = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        row_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      edges_q      <= '0;
      curves_q     <= '0;
      prev_runs_q  <= '0;
      prev_top_q   <= '0;
      prev_empty_q <= 1'b1;
      feat_valid_q <= 1'b0;
      row_ready_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      edges_q      <= edges_d;
      curves_q     <= curves_d;
      prev_runs_q  <= prev_runs_d;
      prev_top_q   <= prev_top_d;
      prev_empty_q <= prev_empty_d;
      feat_valid_q <= feat_valid_d;
      row_ready_q  <= row_ready_d;
      ovf_q        <= ovf_d;
    end
  end

  assign row_ready  = row_ready_q;
  assign edges      = edges_q;
  assign curves     = curves_q;
  assign feat_valid = feat_valid_q;

`ifdef FEATURE_OVF_FLAG_EN
  assign feat_ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_feature_extractor.sv
// ============================================================================
// tb_feature_extractor : randomized self-checking bench with a frame-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_feature_extractor;

  localparam int COLS = 8;
  localparam int ROWS = 8;

  logic            clk;
  logic            rst_n;
  logic [COLS-1:0] row_data;
  logic            row_valid;
  logic            row_ready;
  logic [2:0]      edges;
  logic [3:0]      curves;
  logic            feat_valid;
  logic            feat_ready;
`ifdef FEATURE_OVF_FLAG_EN
  logic            feat_ovf;
`endif

  feature_extractor #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_data   (row_data),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .edges      (edges),
    .curves     (curves),
    .feat_valid (feat_valid),
`ifdef FEATURE_OVF_FLAG_EN
    .feat_ovf   (feat_ovf),
`endif
    .feat_ready (feat_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [COLS-1:0] frame [ROWS];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame-level reference: counts and saturation straight from the rules.
  function automatic void model(output int e, output int c, output int ovf);
    int pr, pt, pe, runs, top, emp;
    logic [COLS-1:0] x, sh;
    e = 0; c = 0; ovf = 0;
    pr = 0; pt = 0; pe = 1;
    for (int r = 0; r < ROWS; r++) begin
      x    = frame[r];
      sh   = x << 1;
      runs = $countones(x & ~sh);
      emp  = (x == 0) ? 1 : 0;
      top  = emp ? 0 : $clog2(int'(x) + 1) - 1;
      if (runs != pr) begin
        if (e < 7) e++; else ovf = 1;
      end
      if (!emp && !pe && (top - pt == 1 || pt - top == 1)) begin
        if (c < 15) c++; else ovf = 1;
      end
      pr = runs; pt = top; pe = emp;
    end
  endfunction

  // Entered at a negedge; returns right after the accepting posedge.
  task automatic send_row(input logic [COLS-1:0] d);
    bit acc;
    int budget;
    budget = 50;
    row_data  = d;
    row_valid = 1'b1;
    forever begin
      acc = row_ready;
      @(posedge clk);
      if (acc) break;
      budget--;
      if (budget == 0) begin
        chk("row_accept_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input int hold_cycles, input bit allow_gap, input string name);
    int e, c, o, gap;
    logic [2:0] e_hold;
    logic [3:0] c_hold;
    model(e, c, o);
    for (int r = 0; r < ROWS; r++) begin
      gap = allow_gap ? $urandom_range(0, 2) : 0;
      repeat (gap) begin
        row_valid = 1'b0;
        row_data  = COLS'($urandom);
        @(negedge clk);
      end
      send_row(frame[r]);
      @(negedge clk);
    end
    row_valid = 1'b0;
    chk({name, "_feat_valid_lat"}, int'(feat_valid), 1);
    chk({name, "_edges"}, int'(edges), e);
    chk({name, "_curves"}, int'(curves), c);
`ifdef FEATURE_OVF_FLAG_EN
    chk({name, "_ovf"}, int'(feat_ovf), o);
`endif
    e_hold = edges;
    c_hold = curves;
    for (int k = 0; k < hold_cycles; k++) begin
      feat_ready = 1'b0;
      row_valid  = 1'($urandom);
      row_data   = COLS'($urandom);
      @(negedge clk);
      chk({name, "_hold_valid"}, int'(feat_valid), 1);
      chk({name, "_hold_ready"}, int'(row_ready), 0);
      chk({name, "_hold_edges"}, int'(edges), int'(e_hold));
      chk({name, "_hold_curves"}, int'(curves), int'(c_hold));
    end
    row_valid  = 1'b0;
    feat_ready = 1'b1;
    @(negedge clk);
    feat_ready = 1'b0;
    chk({name, "_post_valid"}, int'(feat_valid), 0);
    chk({name, "_post_ready"}, int'(row_ready), 1);
    chk({name, "_post_edges"}, int'(edges), 0);
    chk({name, "_post_curves"}, int'(curves), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_edges"}, int'(edges), 0);
    chk({name, "_curves"}, int'(curves), 0);
    chk({name, "_feat_valid"}, int'(feat_valid), 0);
    chk({name, "_row_ready"}, int'(row_ready), 0);
`ifdef FEATURE_OVF_FLAG_EN
    chk({name, "_ovf"}, int'(feat_ovf), 0);
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    row_data   = '0;
    row_valid  = 1'b0;
    feat_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < ROWS; r++) frame[r] = '0;
    run_frame(0, 0, "zeros");

    for (int r = 0; r < ROWS; r++) frame[r] = 8'h18;
    run_frame(1, 1, "vbar");

    for (int r = 0; r < ROWS; r++) frame[r] = 8'(1 << r);
    run_frame(0, 1, "diag");

    for (int r = 0; r < ROWS; r++) frame[r] = (r % 2 == 0) ? 8'h55 : 8'h00;
    run_frame(0, 1, "alt55");

    // Back-to-back: the next frame starts at the negedge right after the handshake.
    for (int r = 0; r < ROWS; r++) frame[r] = 8'(1 << r);
    run_frame(5, 0, "bp");
    run_frame(0, 0, "b2b");

    // Abort a frame with reset after three rows.
    for (int r = 0; r < 3; r++) begin
      send_row(8'hF0 >> r);
      @(negedge clk);
    end
    row_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < ROWS; r++) frame[r] = 8'(1 << r);
    run_frame(0, 1, "after_rst");

    for (int f = 0; f < 25; f++) begin
      for (int r = 0; r < ROWS; r++) begin
        case ($urandom_range(0, 3))
          0:       frame[r] = '0;
          1:       frame[r] = 8'(1 << $urandom_range(0, 7));
          2:       frame[r] = 8'h55;
          default: frame[r] = COLS'($urandom);
        endcase
      end
      run_frame($urandom_range(0, 3), 1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/feature_extractor.md
Name: feature_extractor

Overview:
- Upstream stage of the perceptron classifier.
- Accepts a binary glyph one row per handshake, ROWS rows per frame.
- Accumulates an edge count and a curve count across the frame.
- Presents the two counts as a registered, valid/ready-qualified feature pair: a 3-bit edges value and a 4-bit curves value, exactly as the perceptron consumes them.

Parameters:
- COLS, 8, pixels per row (bit i = column i).
- ROWS, 8, rows per frame (2..16).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- row_data  input  COLS  pixel row; 1 = ink.
- row_valid  input  1  row_data is valid.
- row_ready  output  1  block accepts a row this cycle.
- edges  output  3  saturating edge count.
- curves  output  4  saturating curve count.
- feat_valid  output  1  edges/curves are valid.
- feat_ready  input  1  downstream accepts the feature pair.

Interface decision: one clock, clk; reset rst_n is synchronous and active-low.

Behaviour:
- Reset (rst_n low at a clk edge, including mid-frame or mid-HOLD):
  - State goes to IDLE; row counter = 0; all accumulators cleared.
  - edges = 0, curves = 0, feat_valid = 0, row_ready = 0 during reset.
  - prev_runs = 0, prev_empty = 1.
- Row statistics, combinational per row:
  - runs = number of 0->1 transitions scanning column 0 to COLS-1, with an implicit 0 left of column 0.
  - empty = (row_data == 0).
  - top = index of the highest set bit; don't-care when empty.
- States:
  - IDLE: row_ready = 1. An accepted row (row_valid & row_ready) is processed as row 0 and the state moves to ACCUM.
  - ACCUM: row_ready = 1. Each accepted row is processed. When the accepted row is row ROWS-1, the state moves to HOLD.
  - HOLD: row_ready = 0, feat_valid = 1. edges/curves are held stable. On feat_ready = 1 the state moves to IDLE, feat_valid drops the next cycle, and the accumulators clear.
- Processing an accepted row:
  - edge event: runs != prev_runs. edges += 1, saturating at 7.
  - curve event: !empty & !prev_empty & |top - prev_top| == 1. curves += 1, saturating at 15.
  - Then prev_runs, prev_top and prev_empty are updated from the current row.
  - For row 0 the comparison uses the reset values (prev_runs = 0, prev_empty = 1).
- Latency: feat_valid is asserted on the cycle after the last row is accepted. Outputs come straight from registers.
- row_valid while row_ready = 0 is ignored; no data is lost because the upstream holds the row.
- The block does not stall inside a frame. Gaps of any length (row_valid low) between rows are allowed.
- The HOLD-to-IDLE transition costs one cycle; the first row of the next frame is accepted no earlier than the cycle after the feature handshake.
- Saturation: increments at 7 / 15 are dropped silently (see the optional feature for a flag).
- runs width: clog2(COLS/2+1); top width: clog2(COLS).

Optional Feature:
- Macro: FEATURE_OVF_FLAG_EN.
- With the macro:
  - Adds output port feat_ovf (1 bit, reset 0).
  - feat_ovf is set when any edge or curve event is dropped by saturation within the frame.
  - It is valid with feat_valid and clears with the accumulators.
- Without the macro: the port is absent and saturation is silent.

Decomposition:
- Package feature_pkg:
  - EDGE_W = 3, CURVE_W = 4, EDGE_MAX = 7, CURVE_MAX = 15.
  - State enum {IDLE, ACCUM, HOLD}.
- Sub-module row_stats, purely combinational:
  - Input: row_data.
  - Outputs: runs, empty, top.
  - Instantiated once.

Test Plan:
- All-zero frame (8 rows of 0x00) -> edges = 0, curves = 0; feat_valid asserts the cycle after the 8th accept.
- Vertical bar, every row 0x18 -> edges = 1 (row 0 only), curves = 0.
- Diagonal, row i = 1<<i -> edges = 1, curves = 7.
- Rows alternating 0x55 / 0x00:
  - edges saturates at 7; curves = 0.
  - With FEATURE_OVF_FLAG_EN: feat_ovf = 1.
- Backpressure: feat_ready held low 5 cycles in HOLD:
  - feat_valid stays 1 and edges/curves stay stable.
  - row_ready = 0; row_valid pulses are ignored.
  - feat_ready = 1 -> IDLE; the next frame is accepted the following cycle.
- Reset after 3 rows accepted, then a full diagonal frame:
  - All outputs read 0 during reset.
  - The diagonal frame yields edges = 1, curves = 7 (no residue from the aborted frame).
